// File: rtl/psum_writer.sv
// psum_writer: captures OFIFO psum rows through a 2-entry skid buffer and writes them to the psum SRAM.
// Optional stall counter output enabled by defining PSUM_WRITER_STATS_EN.
module psum_writer #(
    parameter int col     = 8,
    parameter int psum_bw = 16,
    parameter int nij_len = 3,
    parameter int kij_len = 9,
    parameter int a_bw    = 11
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [a_bw-1:0]          base_addr,
    input  logic                     in_valid,
    input  logic [col*psum_bw-1:0]   in_data,
    input  logic                     mem_busy,
    output logic                     mem_cen_n,
    output logic                     mem_wen_n,
    output logic [a_bw-1:0]          mem_a,
    output logic [col*psum_bw-1:0]   mem_d,
    output logic                     busy,
    output logic                     done,
    output logic [1:0]               err
`ifdef PSUM_WRITER_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);
    localparam int RW = col * psum_bw;
    localparam int NW = $clog2(nij_len);
    localparam int KW = $clog2(kij_len);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [a_bw-1:0] base_q, base_d, a_q, a_d;
    logic [NW-1:0]   nij_q, nij_d;
    logic [KW-1:0]   kij_q, kij_d;
    logic [1:0]      cnt_q, cnt_d, err_q, err_d, slot;
    logic [RW-1:0]   buf0_q, buf0_d, buf1_q, buf1_d, mdat_q, mdat_d;
    logic            last_q, last_d, cen_q, cen_d;
    logic            run, pop, push, keep, nij_wrap, kij_wrap;
    logic [a_bw-1:0] wr_addr;

    assign run      = state_q == RUN;
    // Nothing pops once the final write is out; leftovers wait for the next start.
    assign pop      = run && cnt_q != 2'd0 && !mem_busy && !last_q;
    assign push     = run && in_valid;
    assign keep     = push && (cnt_q != 2'd2 || pop);
    assign slot     = cnt_q - {1'b0, pop};
    assign nij_wrap = nij_q == NW'(nij_len - 1);
    assign kij_wrap = kij_q == KW'(kij_len - 1);
    assign wr_addr  = base_q + a_bw'(kij_q) * a_bw'(nij_len) + a_bw'(nij_q);

`ifdef PSUM_WRITER_STATS_EN
    logic [15:0] stall_q, stall_d;
    always_comb begin
        stall_d = (run && cnt_q != 2'd0 && mem_busy && stall_q != 16'hFFFF) ? stall_q + 16'd1 : stall_q;
        stall_d = (start && !run) ? 16'd0 : stall_d;
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stall_q <= '0;
        else        stall_q <= stall_d;
    end
    assign stall_cnt = stall_q;
`endif

    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        nij_d   = nij_q;
        kij_d   = kij_q;
        cnt_d   = cnt_q + {1'b0, keep} - {1'b0, pop};
        buf0_d  = buf0_q;
        buf1_d  = buf1_q;
        last_d  = 1'b0;
        cen_d   = 1'b1;
        a_d     = a_q;
        mdat_d  = mdat_q;
        err_d   = err_q | {in_valid && !run, push && !keep};
        if (pop) begin
            buf0_d = buf1_q;
            cen_d  = 1'b0;
            a_d    = wr_addr;
            mdat_d = buf0_q;
            nij_d  = nij_wrap ? '0 : nij_q + 1'b1;
            kij_d  = nij_wrap ? (kij_wrap ? '0 : kij_q + 1'b1) : kij_q;
            last_d = nij_wrap && kij_wrap;
        end
        if (keep && slot == 2'd0) buf0_d = in_data;
        if (keep && slot != 2'd0) buf1_d = in_data;
        if (run && last_q) state_d = DONE;
        if (start && !run) begin
            state_d = RUN;
            base_d  = base_addr;
            nij_d   = '0;
            kij_d   = '0;
            cnt_d   = '0;
            err_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            base_q  <= '0;
            nij_q   <= '0;
            kij_q   <= '0;
            cnt_q   <= '0;
            buf0_q  <= '0;
            buf1_q  <= '0;
            last_q  <= 1'b0;
            cen_q   <= 1'b1;
            a_q     <= '0;
            mdat_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            base_q  <= base_d;
            nij_q   <= nij_d;
            kij_q   <= kij_d;
            cnt_q   <= cnt_d;
            buf0_q  <= buf0_d;
            buf1_q  <= buf1_d;
            last_q  <= last_d;
            cen_q   <= cen_d;
            a_q     <= a_d;
            mdat_q  <= mdat_d;
            err_q   <= err_d;
        end
    end

    assign mem_cen_n = cen_q;
    assign mem_wen_n = cen_q;
    assign mem_a     = a_q;
    assign mem_d     = mdat_q;
    assign busy      = run;
    assign done      = state_q == DONE;
    assign err       = err_q;
endmodule

// File: tb/tb_psum_writer.sv
// tb_psum_writer: directed checks of psum_writer write sequencing, skid buffer, errors and reset.
module tb_psum_writer;
    logic          clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, mem_busy = 1'b0;
    logic [10:0]   base_addr = '0;
    logic [127:0]  in_data = '0;
    logic          mem_cen_n, mem_wen_n, busy, done;
    logic [10:0]   mem_a;
    logic [127:0]  mem_d;
    logic [1:0]    err;
`ifdef PSUM_WRITER_STATS_EN
    logic [15:0]   stall_cnt;
`endif
    int n_cmp = 0, n_bad = 0;

    psum_writer dut (
        .clk(clk), .reset(reset), .start(start), .base_addr(base_addr),
        .in_valid(in_valid), .in_data(in_data), .mem_busy(mem_busy),
        .mem_cen_n(mem_cen_n), .mem_wen_n(mem_wen_n), .mem_a(mem_a), .mem_d(mem_d),
        .busy(busy), .done(done), .err(err)
`ifdef PSUM_WRITER_STATS_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] row(input int i);
        logic [127:0] r;
        for (int l = 0; l < 8; l++) r[l*16 +: 16] = 16'(i * 16 + l);
        return r;
    endfunction

    task automatic start_pass(input logic [10:0] base);
        base_addr = base;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic push_and_check(input int id, input logic [10:0] addr);
        in_valid = 1'b1;
        in_data  = row(id);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wr_cen", 128'(mem_cen_n), 128'd0);
        chk("wr_wen", 128'(mem_wen_n), 128'd0);
        chk("wr_addr", 128'(mem_a), 128'(addr));
        chk("wr_data", mem_d, row(id));
    endtask

    task automatic run_pass(input logic [10:0] base, input int id0);
        start_pass(base);
        chk("pass_busy", 128'(busy), 128'd1);
        for (int i = 0; i < 27; i++) push_and_check(id0 + i, 11'(base + 11'(i)));
        chk("pre_done", 128'(done), 128'd0);
        @(negedge clk);
        chk("done", 128'(done), 128'd1);
        chk("done_busy", 128'(busy), 128'd0);
        chk("done_cen", 128'(mem_cen_n), 128'd1);
    endtask

    logic [6:0] t3_v   = 7'b0001111;
    logic [6:0] t3_b   = 7'b0000101;
    logic [6:0] t3_cen = 7'b1000101;

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_cen", 128'(mem_cen_n), 128'd1);
        chk("rst_wen", 128'(mem_wen_n), 128'd1);
        chk("rst_a", 128'(mem_a), 128'd0);
        chk("rst_d", mem_d, 128'd0);
        chk("rst_busy", 128'(busy), 128'd0);
        chk("rst_done", 128'(done), 128'd0);
        chk("rst_err", 128'(err), 128'd0);
        reset = 1'b1;
        @(negedge clk);

        run_pass(11'h100, 0);
        chk("pass1_err", 128'(err), 128'd0);

        start_pass(11'h200);
        mem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1;
            in_data  = row(100 + k);
            @(negedge clk);
        end
        in_valid = 1'b0;
        mem_busy = 1'b0;
        @(negedge clk);
        chk("ovf_cen0", 128'(mem_cen_n), 128'd0);
        chk("ovf_a0", 128'(mem_a), 128'h200);
        chk("ovf_d0", mem_d, row(100));
        @(negedge clk);
        chk("ovf_cen1", 128'(mem_cen_n), 128'd0);
        chk("ovf_a1", 128'(mem_a), 128'h201);
        chk("ovf_d1", mem_d, row(101));
        @(negedge clk);
        chk("ovf_drop", 128'(mem_cen_n), 128'd1);
        chk("ovf_err", 128'(err), 128'd1);

        begin
            int j = 0;
            for (int k = 0; k < 7; k++) begin
                in_valid = t3_v[k];
                mem_busy = t3_b[k];
                in_data  = row(200 + k);
                @(negedge clk);
                chk("tgl_cen", 128'(mem_cen_n), 128'(t3_cen[k]));
                if (!t3_cen[k]) begin
                    chk("tgl_a", 128'(mem_a), 128'(11'h202 + 11'(j)));
                    chk("tgl_d", mem_d, row(200 + j));
                    j++;
                end
            end
            chk("tgl_cnt", 128'(j), 128'd4);
            chk("tgl_err", 128'(err), 128'd1);
        end
        in_valid = 1'b0;
        mem_busy = 1'b0;

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        run_pass(11'h7FE, 300);
        chk("wrap_err", 128'(err), 128'd0);

        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = row(999);
        @(negedge clk);
        in_valid = 1'b0;
        chk("idle_nowr", 128'(mem_cen_n), 128'd1);
        chk("idle_err", 128'(err), 128'd2);
        chk("idle_busy", 128'(busy), 128'd0);
        start_pass(11'h040);
        chk("start_clr", 128'(err), 128'd0);
        for (int i = 0; i < 5; i++) push_and_check(500 + i, 11'h040 + 11'(i));
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_cen", 128'(mem_cen_n), 128'd1);
        chk("mid_rst_busy", 128'(busy), 128'd0);
        chk("mid_rst_a", 128'(mem_a), 128'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);

`ifdef PSUM_WRITER_STATS_EN
        start_pass(11'h000);
        mem_busy = 1'b1;
        in_valid = 1'b1;
        in_data  = row(7);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        chk("stall_cnt", 128'(stall_cnt), 128'd10);
        mem_busy = 1'b0;
        @(negedge clk);
        chk("stall_wr", mem_d, row(7));
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
